// File: rtl/bowling_pkg.sv
// Shared constants and FSM state type for the bowling throw-entry front end.
package bowling_pkg;

    localparam logic [3:0] PINS       = 4'd10;
    localparam logic [3:0] LAST_FRAME = 4'd10;

    typedef enum logic [1:0] {
        IDLE,
        CHECK,
        PULSE
    } entry_state_t;

endpackage

// File: rtl/button_debouncer.sv
// Synchronises a raw pushbutton, debounces it and emits one pulse per accepted press.
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic btn,
    output logic press
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          sync1;
    logic          sync2;
    logic          stable;
    logic [CW-1:0] count;

    // Stable level comes out of reset as "pressed" so a button held across reset release
    // must first be seen released before it can produce a request.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            stable <= 1'b1;
            count  <= '0;
            press  <= 1'b0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
            press <= 1'b0;
            if (sync2 == stable) begin
                count <= '0;
            end else if (count == CW'(DEBOUNCE_CYCLES - 1)) begin
                stable <= sync2;
                count  <= '0;
                press  <= sync2;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/bowling_throw_entry.sv
// Throw-entry stage: debounced button plus pin switches become an N/UPD strobe pair,
// with frame/ball/pin tracking that rejects impossible entries.
module bowling_throw_entry
    import bowling_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int UPD_HIGH_CYCLES = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] SW,
    input  logic       BTN,
    input  logic       Done,
    output logic [3:0] N,
    output logic       UPD,
    output logic       Error,
    output logic [3:0] pins_left,
    output logic [3:0] frame,
    output logic [1:0] ball,
    output logic       game_over
);

    localparam int PW = $clog2(UPD_HIGH_CYCLES + 1);

    entry_state_t  state;
    logic          press;
    logic [3:0]    sw_cap;
    logic          entry_ok;
    logic          strike10;
    logic [PW-1:0] pulse_cnt;
    logic          entry_ok_now;
    logic [3:0]    rem;

    button_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debouncer (
        .clock (clock),
        .reset (reset),
        .btn   (BTN),
        .press (press)
    );

    assign entry_ok_now = (SW <= PINS) && (SW <= pins_left) && !Done && !game_over;
    assign rem          = pins_left - sw_cap;

    // N is loaded when the request is seen so it is stable a full clock before UPD rises;
    // the tracker advances one clock later, together with the UPD rise.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            N         <= 4'd0;
            UPD       <= 1'b0;
            Error     <= 1'b0;
            pins_left <= PINS;
            frame     <= 4'd1;
            ball      <= 2'd1;
            game_over <= 1'b0;
            sw_cap    <= 4'd0;
            entry_ok  <= 1'b0;
            strike10  <= 1'b0;
            pulse_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (press) begin
                        sw_cap   <= SW;
                        entry_ok <= entry_ok_now;
                        if (entry_ok_now) begin
                            N <= SW;
                        end
                        state <= CHECK;
                    end
                end
                CHECK: begin
                    if (entry_ok) begin
                        Error     <= 1'b0;
                        UPD       <= 1'b1;
                        pulse_cnt <= PW'(1);
                        state     <= PULSE;
                        if (frame != LAST_FRAME) begin
                            if (ball == 2'd1 && sw_cap != PINS) begin
                                ball      <= 2'd2;
                                pins_left <= rem;
                            end else begin
                                frame     <= frame + 4'd1;
                                ball      <= 2'd1;
                                pins_left <= PINS;
                            end
                        end else begin
                            case (ball)
                                2'd1: begin
                                    ball      <= 2'd2;
                                    strike10  <= (sw_cap == PINS);
                                    pins_left <= (sw_cap == PINS) ? PINS : rem;
                                end
                                2'd2: begin
                                    if (rem == 4'd0 || strike10) begin
                                        ball      <= 2'd3;
                                        pins_left <= (rem == 4'd0) ? PINS : rem;
                                    end else begin
                                        game_over <= 1'b1;
                                        pins_left <= rem;
                                    end
                                end
                                default: begin
                                    game_over <= 1'b1;
                                    pins_left <= rem;
                                end
                            endcase
                        end
                    end else begin
                        Error <= 1'b1;
                        state <= IDLE;
                    end
                end
                PULSE: begin
                    if (pulse_cnt == PW'(UPD_HIGH_CYCLES)) begin
                        UPD   <= 1'b0;
                        state <= IDLE;
                    end else begin
                        pulse_cnt <= pulse_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bowling_throw_entry.sv
// Directed bench for bowling_throw_entry: bounce, over-count, lockouts, full games and reset.
module tb_bowling_throw_entry;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] SW    = 4'd0;
    logic       BTN   = 1'b0;
    logic       Done  = 1'b0;
    logic [3:0] N;
    logic       UPD;
    logic       Error;
    logic [3:0] pins_left;
    logic [3:0] frame;
    logic [1:0] ball;
    logic       game_over;

    int         assertCount = 0;
    int         failCount   = 0;
    int         updCount    = 0;
    int         curWidth    = 0;
    int         lastWidth   = 0;
    int         base        = 0;
    logic [3:0] prevN       = 4'd0;
    logic [3:0] nBeforeRise = 4'd0;
    logic       prevUpd     = 1'b0;
    bit         seen        = 1'b0;

    always #5 clock = ~clock;

    bowling_throw_entry #(
        .DEBOUNCE_CYCLES(4),
        .UPD_HIGH_CYCLES(2)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .SW        (SW),
        .BTN       (BTN),
        .Done      (Done),
        .N         (N),
        .UPD       (UPD),
        .Error     (Error),
        .pins_left (pins_left),
        .frame     (frame),
        .ball      (ball),
        .game_over (game_over)
    );

    // Counts UPD pulses, their width, and the N value one clock before each rise.
    always @(negedge clock) begin
        if (UPD && !prevUpd) begin
            updCount    = updCount + 1;
            nBeforeRise = prevN;
            curWidth    = 1;
        end else if (UPD) begin
            curWidth = curWidth + 1;
        end else if (prevUpd) begin
            lastWidth = curWidth;
        end
        prevUpd = UPD;
        prevN   = N;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic checkTrack(input string tag, input int expFrame, input int expBall, input int expPins);
        checkOutput({tag, "_frame"}, 32'(frame), 32'(expFrame));
        checkOutput({tag, "_ball"}, 32'(ball), 32'(expBall));
        checkOutput({tag, "_pins"}, 32'(pins_left), 32'(expPins));
    endtask

    task automatic applyReset();
        @(negedge clock);
        reset = 1'b0;
        BTN   = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        repeat (10) @(negedge clock);
    endtask

    task automatic applyStimulus(input logic [3:0] sw);
        @(negedge clock);
        SW  = sw;
        BTN = 1'b1;
        repeat (10) @(negedge clock);
        BTN = 1'b0;
        repeat (12) @(negedge clock);
    endtask

    initial begin
        $display("[TB] start");
        repeat (2) @(negedge clock);
        checkOutput("rst_N", 32'(N), 32'd0);
        checkOutput("rst_UPD", 32'(UPD), 32'd0);
        checkOutput("rst_Error", 32'(Error), 32'd0);
        checkOutput("rst_game_over", 32'(game_over), 32'd0);
        checkTrack("rst", 1, 1, 10);
        reset = 1'b1;
        repeat (10) @(negedge clock);

        // Test 1: bouncing press followed by a steady hold, with exact latency checks
        base = updCount;
        SW   = 4'd4;
        for (int i = 0; i < 6; i++) begin
            BTN = (i % 2 == 0);
            @(negedge clock);
        end
        BTN = 1'b1;
        repeat (6) @(negedge clock);
        checkOutput("t1_N_early", 32'(N), 32'd0);
        @(negedge clock);
        checkOutput("t1_N_loaded", 32'(N), 32'd4);
        checkOutput("t1_UPD_before", 32'(UPD), 32'd0);
        @(negedge clock);
        checkOutput("t1_UPD_rise", 32'(UPD), 32'd1);
        @(negedge clock);
        checkOutput("t1_UPD_hold", 32'(UPD), 32'd1);
        @(negedge clock);
        checkOutput("t1_UPD_fall", 32'(UPD), 32'd0);
        repeat (6) @(negedge clock);
        BTN = 1'b0;
        repeat (12) @(negedge clock);
        checkOutput("t1_upd_count", 32'(updCount - base), 32'd1);
        checkOutput("t1_width", 32'(lastWidth), 32'd2);
        checkOutput("t1_n_setup", 32'(nBeforeRise), 32'd4);
        checkTrack("t1", 1, 2, 6);

        // Test 2: over-count rejection in the middle of a frame
        applyReset();
        base = updCount;
        applyStimulus(4'd7);
        checkOutput("t2_upd7", 32'(updCount - base), 32'd1);
        checkTrack("t2_a", 1, 2, 3);
        applyStimulus(4'd5);
        checkOutput("t2_err5", 32'(Error), 32'd1);
        checkOutput("t2_upd5", 32'(updCount - base), 32'd1);
        checkOutput("t2_N5", 32'(N), 32'd7);
        checkTrack("t2_b", 1, 2, 3);
        applyStimulus(4'd3);
        checkOutput("t2_upd3", 32'(updCount - base), 32'd2);
        checkOutput("t2_err3", 32'(Error), 32'd0);
        checkOutput("t2_N3", 32'(N), 32'd3);
        checkTrack("t2_c", 2, 1, 10);

        // Test 3: out-of-range switch value and the Done lockout
        base = updCount;
        applyStimulus(4'd11);
        checkOutput("t3_err11", 32'(Error), 32'd1);
        checkOutput("t3_upd11", 32'(updCount - base), 32'd0);
        checkTrack("t3_a", 2, 1, 10);
        Done = 1'b1;
        applyStimulus(4'd2);
        checkOutput("t3_errDone", 32'(Error), 32'd1);
        checkOutput("t3_updDone", 32'(updCount - base), 32'd0);
        checkOutput("t3_NDone", 32'(N), 32'd3);
        checkTrack("t3_b", 2, 1, 10);
        Done = 1'b0;

        // Test 4: perfect game
        applyReset();
        base = updCount;
        for (int i = 1; i <= 12; i++) begin
            applyStimulus(4'd10);
            if (i == 9)  checkTrack("t4_s9", 10, 1, 10);
            if (i == 10) checkTrack("t4_s10", 10, 2, 10);
            if (i == 11) begin
                checkTrack("t4_s11", 10, 3, 10);
                checkOutput("t4_go11", 32'(game_over), 32'd0);
            end
        end
        checkOutput("t4_upd12", 32'(updCount - base), 32'd12);
        checkOutput("t4_go12", 32'(game_over), 32'd1);
        checkOutput("t4_err12", 32'(Error), 32'd0);
        applyStimulus(4'd0);
        checkOutput("t4_err13", 32'(Error), 32'd1);
        checkOutput("t4_upd13", 32'(updCount - base), 32'd12);

        // Test 5: open tenth frame, then a spare tenth frame
        applyReset();
        base = updCount;
        repeat (18) applyStimulus(4'd0);
        checkTrack("t5_f10", 10, 1, 10);
        applyStimulus(4'd3);
        checkTrack("t5_b2", 10, 2, 7);
        applyStimulus(4'd4);
        checkOutput("t5_go", 32'(game_over), 32'd1);
        checkOutput("t5_upd", 32'(updCount - base), 32'd20);
        applyStimulus(4'd1);
        checkOutput("t5_err", 32'(Error), 32'd1);
        checkOutput("t5_upd_after", 32'(updCount - base), 32'd20);
        applyReset();
        repeat (18) applyStimulus(4'd0);
        applyStimulus(4'd9);
        checkTrack("t5_sp1", 10, 2, 1);
        applyStimulus(4'd1);
        checkTrack("t5_sp2", 10, 3, 10);
        checkOutput("t5_sp_go", 32'(game_over), 32'd0);

        // Test 6: asynchronous reset in mid-pulse, button held across release
        applyReset();
        applyStimulus(4'd12);
        checkOutput("t6_err_pre", 32'(Error), 32'd1);
        @(negedge clock);
        SW   = 4'd5;
        BTN  = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clock);
            if (UPD) seen = 1'b1;
        end
        checkOutput("t6_upd_seen", 32'(seen), 32'd1);
        checkOutput("t6_N_pre", 32'(N), 32'd5);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("t6_UPD", 32'(UPD), 32'd0);
        checkOutput("t6_N", 32'(N), 32'd0);
        checkOutput("t6_Error", 32'(Error), 32'd0);
        checkTrack("t6_rst", 1, 1, 10);
        @(negedge clock);
        base = updCount;
        @(negedge clock);
        reset = 1'b1;
        repeat (20) @(negedge clock);
        BTN = 1'b0;
        repeat (12) @(negedge clock);
        checkOutput("t6_held_upd", 32'(updCount - base), 32'd0);
        checkOutput("t6_held_N", 32'(N), 32'd0);
        applyStimulus(4'd2);
        checkOutput("t6_next_upd", 32'(updCount - base), 32'd1);
        checkOutput("t6_next_N", 32'(N), 32'd2);
        checkTrack("t6_next", 1, 2, 8);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
